// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants for the forwarding / interlock controller.
// Forward-select encoding, tag counter widths and saturating counter helper.
package fwd_hazard_unit_pkg;

  localparam int unsigned FWD_REGFILE = 0;
  localparam int unsigned CNT_W       = 3;
  localparam int unsigned KCTR_W      = 2;

  localparam logic KILL_ON  = 1'b1;
  localparam logic STALL_ON = 1'b1;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_tag_stage.sv
// hz_tag_stage: one in-flight destination tag {valid, we, load, rd, cnt}.
// Ports: v/we/ld/rd/cnt _i from the previous slot, same fields _o registered.
module hz_tag_stage
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned RA_W = 5,
  // Stage 1 captures the fresh load latency; later stages count it down.
  parameter bit          DEC  = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              v_i,
  input  logic              we_i,
  input  logic              ld_i,
  input  logic [RA_W-1:0]   rd_i,
  input  logic [CNT_W-1:0]  cnt_i,
  output logic              v_o,
  output logic              we_o,
  output logic              ld_o,
  output logic [RA_W-1:0]   rd_o,
  output logic [CNT_W-1:0]  cnt_o
);

  logic             v_q, we_q, ld_q;
  logic [RA_W-1:0]  rd_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_i;
    if (DEC && (cnt_i != '0))
      cnt_d = cnt_i - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q   <= 1'b0;
      we_q  <= 1'b0;
      ld_q  <= 1'b0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_i;
      we_q  <= we_i;
      ld_q  <= ld_i;
      rd_q  <= rd_i;
      cnt_q <= cnt_d;
    end
  end

  assign v_o   = v_q;
  assign we_o  = we_q;
  assign ld_o  = ld_q;
  assign rd_o  = rd_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: load-use interlock, redirect squash and operand forwarding.
// In: decode tags, redirect. Out: stall, kill, fwd_sel_a/b, wb_we/wb_rd,
// perf_stall/perf_flush (counting only when HAZ_PERF_CNT_EN is defined).
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned NSTAGE     = 2,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned KILL_SLOTS = 1,
  parameter int unsigned RA_W       = 5,
  parameter int unsigned FS_W       = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_rs1_use,
  input  logic            id_rs2_use,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_we,
  input  logic            id_load,
  input  logic            redirect,
  output logic            stall,
  output logic            kill,
  output logic [FS_W-1:0] fwd_sel_a,
  output logic [FS_W-1:0] fwd_sel_b,
  output logic            wb_we,
  output logic [RA_W-1:0] wb_rd,
  output logic [31:0]     perf_stall,
  output logic [31:0]     perf_flush
);

  logic             in_v, in_we, in_ld;
  logic [RA_W-1:0]  in_rd;
  logic [CNT_W-1:0] in_cnt;

  logic             s_v   [1:NSTAGE];
  logic             s_we  [1:NSTAGE];
  logic             s_ld  [1:NSTAGE];
  logic [RA_W-1:0]  s_rd  [1:NSTAGE];
  logic [CNT_W-1:0] s_cnt [1:NSTAGE];

  logic [FS_W-1:0]   sel_a, sel_b;
  logic              busy_a, busy_b;
  logic [KCTR_W-1:0] kctr_q, kctr_d;

  // Killed or stalled slots enter stage 1 as fully cleared bubbles.
  assign in_v   = id_valid & ~kill & ~stall;
  assign in_we  = in_v & id_we;
  assign in_ld  = in_v & id_load;
  assign in_rd  = in_v ? id_rd : '0;
  assign in_cnt = in_ld ? CNT_W'(LOAD_LAT) : '0;

  for (genvar k = 1; k <= NSTAGE; k++) begin : g_stage
    if (k == 1) begin : g_head
      hz_tag_stage #(.RA_W(RA_W), .DEC(1'b0)) u_tag (
        .clk    (clk),
        .reset_n(reset_n),
        .v_i    (in_v),
        .we_i   (in_we),
        .ld_i   (in_ld),
        .rd_i   (in_rd),
        .cnt_i  (in_cnt),
        .v_o    (s_v[k]),
        .we_o   (s_we[k]),
        .ld_o   (s_ld[k]),
        .rd_o   (s_rd[k]),
        .cnt_o  (s_cnt[k])
      );
    end else begin : g_tail
      hz_tag_stage #(.RA_W(RA_W), .DEC(1'b1)) u_tag (
        .clk    (clk),
        .reset_n(reset_n),
        .v_i    (s_v[k-1]),
        .we_i   (s_we[k-1]),
        .ld_i   (s_ld[k-1]),
        .rd_i   (s_rd[k-1]),
        .cnt_i  (s_cnt[k-1]),
        .v_o    (s_v[k]),
        .we_o   (s_we[k]),
        .ld_o   (s_ld[k]),
        .rd_o   (s_rd[k]),
        .cnt_o  (s_cnt[k])
      );
    end
  end

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    sel_a  = FS_W'(FWD_REGFILE);
    sel_b  = FS_W'(FWD_REGFILE);
    busy_a = 1'b0;
    busy_b = 1'b0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (s_v[k] && s_we[k] && (s_rd[k] == id_rs1) &&
          (id_rs1 != '0) && id_rs1_use) begin
        sel_a  = FS_W'(k);
        busy_a = s_ld[k] && (s_cnt[k] != '0);
      end
      if (s_v[k] && s_we[k] && (s_rd[k] == id_rs2) &&
          (id_rs2 != '0) && id_rs2_use) begin
        sel_b  = FS_W'(k);
        busy_b = s_ld[k] && (s_cnt[k] != '0);
      end
    end
  end

  // Gated by reset so a redirect held during reset cannot leak out.
  assign kill  = reset_n & (redirect | (kctr_q != '0));
  assign stall = id_valid & ~kill & (busy_a | busy_b);

  assign fwd_sel_a = stall ? '0 : sel_a;
  assign fwd_sel_b = stall ? '0 : sel_b;

  // The redirect cycle itself is the first squashed slot.
  always_comb begin
    kctr_d = kctr_q;
    if (redirect)
      kctr_d = KCTR_W'(KILL_SLOTS - 1);
    else if (kctr_q != '0)
      kctr_d = kctr_q - KCTR_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) kctr_q <= '0;
    else          kctr_q <= kctr_d;
  end

  assign wb_we = s_v[NSTAGE] & s_we[NSTAGE] & (s_rd[NSTAGE] != '0);
  assign wb_rd = s_rd[NSTAGE];

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] ps_q, ps_d, pf_q, pf_d;

  assign ps_d = stall ? sat_inc(ps_q) : ps_q;
  assign pf_d = kill  ? sat_inc(pf_q) : pf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps_q <= '0;
      pf_q <= '0;
    end else begin
      ps_q <= ps_d;
      pf_q <= pf_d;
    end
  end

  assign perf_stall = ps_q;
  assign perf_flush = pf_q;
`else
  assign perf_stall = 32'd0;
  assign perf_flush = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed pipeline scenarios with a
// scoreboard queue of expected per-cycle outputs.
module tb_fwd_hazard_unit;

`ifdef HAZ_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  localparam logic [4:0]  DC  = 5'bx;
  localparam logic [31:0] DCW = 32'bx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid, id_rs1_use, id_rs2_use;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_we, id_load, redirect;
  logic       stall, kill, wb_we;
  logic [2:0] fwd_sel_a, fwd_sel_b;
  logic [4:0] wb_rd;
  logic [31:0] perf_stall, perf_flush;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       t;
    logic        st;
    logic        kl;
    logic [2:0]  fa;
    logic [2:0]  fb;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] ps;
    logic [31:0] pf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fwd_hazard_unit #(
    .NSTAGE(2), .LOAD_LAT(1), .KILL_SLOTS(2), .RA_W(5), .FS_W(3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .id_valid  (id_valid),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .id_rs1_use(id_rs1_use),
    .id_rs2_use(id_rs2_use),
    .id_rd     (id_rd),
    .id_we     (id_we),
    .id_load   (id_load),
    .redirect  (redirect),
    .stall     (stall),
    .kill      (kill),
    .fwd_sel_a (fwd_sel_a),
    .fwd_sel_b (fwd_sel_b),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .perf_stall(perf_stall),
    .perf_flush(perf_flush)
  );

  task automatic chk(input string t, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", t, got, exp);
    end
  endtask

  task automatic push(input string t, input logic st, input logic kl,
                      input logic [2:0] fa, input logic [2:0] fb,
                      input logic we, input logic [4:0] rd,
                      input logic [31:0] ps, input logic [31:0] pf);
    exp_t e;
    e.t = t; e.st = st; e.kl = kl; e.fa = fa; e.fb = fb;
    e.we = we; e.rd = rd; e.ps = ps; e.pf = pf;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.t, ".stall"}, 32'(stall), 32'(e.st));
    chk({e.t, ".kill"},  32'(kill),  32'(e.kl));
    chk({e.t, ".fsa"},   32'(fwd_sel_a), 32'(e.fa));
    chk({e.t, ".fsb"},   32'(fwd_sel_b), 32'(e.fb));
    chk({e.t, ".wbwe"},  32'(wb_we), 32'(e.we));
    if (!$isunknown(e.rd))
      chk({e.t, ".wbrd"}, 32'(wb_rd), 32'(e.rd));
    if (!$isunknown(e.ps))
      chk({e.t, ".pstall"}, perf_stall, e.ps);
    if (!$isunknown(e.pf))
      chk({e.t, ".pflush"}, perf_flush, e.pf);
  endtask

  task automatic cyc(input string t, input logic v,
                     input logic [4:0] r1, input logic u1,
                     input logic [4:0] r2, input logic u2,
                     input logic [4:0] rd, input logic we,
                     input logic ld, input logic rdr,
                     input logic st, input logic kl,
                     input logic [2:0] fa, input logic [2:0] fb,
                     input logic wwe, input logic [4:0] wrd,
                     input logic [31:0] ps = DCW,
                     input logic [31:0] pf = DCW);
    @(posedge clk);
    #1;
    id_valid = v; id_rs1 = r1; id_rs1_use = u1;
    id_rs2 = r2; id_rs2_use = u2; id_rd = rd;
    id_we = we; id_load = ld; redirect = rdr;
    push(t, st, kl, fa, fb, wwe, wrd, ps, pf);
    @(negedge clk);
    sample();
  endtask

  task automatic idle(input string t, input logic wwe,
                      input logic [4:0] wrd,
                      input logic [31:0] ps = DCW,
                      input logic [31:0] pf = DCW);
    cyc(t, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, wwe, wrd, ps, pf);
  endtask

  initial begin
    reset_n = 1'b0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_use = 0;
    id_rs2_use = 0; id_rd = 0; id_we = 0; id_load = 0; redirect = 0;
    @(negedge clk);
    @(negedge clk);
    push("rst", 0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    #1 reset_n = 1'b1;

    // forward from stage 1 on rs1 only
    cyc("t1_add",   1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, DC);
    cyc("t1_fwd",   1, 5, 1, 3, 1, 9, 1, 0, 0, 0, 0, 1, 0, 0, DC);
    idle("t1_wb5",  1, 5);
    idle("t1_wb9",  1, 9);

    // youngest wins, x0 never forwards or writes, rs_use gates
    cyc("t3_x8a",   1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, DC);
    cyc("t3_x8b",   1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, DC);
    cyc("t3_young", 1, 8, 1, 8, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1, 8);
    cyc("t3_x0",    1, 0, 1, 8, 1, 3, 1, 0, 0, 0, 0, 0, 2, 1, 8);
    idle("t3_wbx0", 0, 0);
    cyc("t3_use",   1, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 3);

    // load-use: one stall then forward from stage 2
    cyc("t2_lw",    1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0, DC);
    cyc("t2_stall", 1, 6, 1, 6, 1, 7, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("t2_fwd",   1, 6, 1, 6, 1, 7, 1, 0, 0, 0, 0, 2, 2, 1, 6,
        32'(PERF), 32'd0);
    idle("t2_bub",  0, DC);
    cyc("t2_wt",    1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 7);

    // redirect squashes two slots
    cyc("t4_redir", 1, 0, 0, 0, 0, 10, 1, 0, 1, 0, 1, 0, 0, 0, DC);
    cyc("t4_k2",    1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc("t4_go",    1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0, 0, DC);
    idle("t4_bub1", 0, DC);
    idle("t4_wb12", 1, 12, DCW, 32'(2 * PERF));

    // redirect beats a load-use stall
    cyc("t5_lw",    1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0, DC);
    cyc("t5_rdst",  1, 6, 1, 6, 1, 7, 1, 0, 1, 0, 1, 1, 1, 0, DC);
    cyc("t5_k2",    1, 6, 1, 6, 1, 7, 1, 0, 0, 0, 1, 2, 2, 1, 6);
    cyc("t5_go",    1, 6, 1, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0, 0, DC);
    idle("t5_bub",  0, DC);
    idle("t5_wb13", 1, 13, 32'(PERF), 32'(4 * PERF));

    // async reset in the middle of a stall
    cyc("t6_lw",    1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0, DC);
    cyc("t6_stall", 1, 6, 1, 6, 1, 7, 1, 0, 0, 1, 0, 0, 0, 0, DC);
    #1 reset_n = 1'b0;
    #1;
    push("t6_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    id_valid = 0;
    @(negedge clk);
    #1 reset_n = 1'b1;
    cyc("t6_post",  1, 6, 1, 6, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, DC);
    idle("t6_bub",  0, DC);
    idle("t6_wb7",  1, 7);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
